cla: RTL and testbench



---
 rtl/cla.sv | 158 +++++++++++++++
 tb/tb_cla.sv | 137 +++++++++++++
 2 files changed

// File: rtl/cla.sv
// cla: registered two-level carry-lookahead adder, {cout,s} = a + b + cin.
// Latency: one cycle, inputs to registered outputs. Throughput: one add per cycle.
// Backpressure: none; a new operand pair is accepted on every edge.
// Ports: clk_1Hz (clock), rst (sync active-high), a/b (WIDTH operands), cin,
//        s (sum), cout (carry-out), pg/gg (block propagate/generate for cascading).
module cla #(
  parameter int WIDTH = 4
) (
  input  logic             clk_1Hz,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             pg,
  output logic             gg
);

  // Only whole 4-bit groups are supported.
  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_bad_width
    $error("cla: WIDTH must be a positive multiple of 4");
  end

  localparam int NG = WIDTH / 4;     // 4-bit groups
  localparam int NB = (NG + 3) / 4;  // blocks of up to 4 groups

  // Lookahead carry into position n (0..4) of a 4-wide slice, written as a
  // flat sum of products: OR_m (gv[m] & pv[m+1..n-1]) | (pv[0..n-1] & ci).
  function automatic logic carry4(input logic [3:0] gv, input logic [3:0] pv,
                                  input logic ci, input int n);
    logic r;
    logic t;
    r = 1'b0;
    for (int m = 0; m < 4; m++) begin
      if (m < n) begin
        t = gv[m];
        for (int q = m + 1; q < 4; q++) begin
          if (q < n) t = t & pv[q];
        end
        r = r | t;
      end
    end
    t = ci;
    for (int q = 0; q < 4; q++) begin
      if (q < n) t = t & pv[q];
    end
    return r | t;
  endfunction

  logic [WIDTH-1:0] g, p, c;
  // Group G/P padded to whole blocks: pad groups are pure propagate (g=0,p=1)
  // so they pass the carry through and leave block G/P unchanged.
  logic [4*NB-1:0]  grp_g, grp_p;
  logic [4*NB-1:0]  grp_c;
  logic [NB-1:0]    blk_g, blk_p;
  logic [NB-1:0]    blk_c;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             pg_d, pg_q;
  logic             gg_d, gg_q;

  always_comb begin
    logic t;
    g     = a & b;
    p     = a ^ b;
    grp_g = '0;
    grp_p = '1;
    grp_c = '0;
    blk_g = '0;
    blk_p = '0;
    blk_c = '0;
    c     = '0;
    cout_d = 1'b0;
    gg_d   = 1'b0;

    // First level: group generate/propagate per 4-bit slice.
    for (int k = 0; k < NG; k++) begin
      grp_g[k] = carry4(g[4*k +: 4], p[4*k +: 4], 1'b0, 4);
      grp_p[k] = &p[4*k +: 4];
    end

    // Block generate/propagate over 4 groups.
    for (int bk = 0; bk < NB; bk++) begin
      blk_g[bk] = carry4(grp_g[4*bk +: 4], grp_p[4*bk +: 4], 1'b0, 4);
      blk_p[bk] = &grp_p[4*bk +: 4];
    end

    // Block carry-ins, flat expansion across blocks (single block: just cin).
    for (int bk = 0; bk < NB; bk++) begin
      t = cin;
      for (int q = 0; q < NB; q++) begin
        if (q < bk) t = t & blk_p[q];
      end
      blk_c[bk] = t;
      for (int m = 0; m < NB; m++) begin
        if (m < bk) begin
          t = blk_g[m];
          for (int q = 0; q < NB; q++) begin
            if ((q > m) && (q < bk)) t = t & blk_p[q];
          end
          blk_c[bk] = blk_c[bk] | t;
        end
      end
    end

    // Block-level carry-out and cin-independent generate use the same expansion.
    t = cin;
    for (int q = 0; q < NB; q++) t = t & blk_p[q];
    cout_d = t;
    for (int m = 0; m < NB; m++) begin
      t = blk_g[m];
      for (int q = 0; q < NB; q++) begin
        if (q > m) t = t & blk_p[q];
      end
      cout_d = cout_d | t;
      gg_d   = gg_d | t;
    end

    // Group carry-ins inside each block.
    for (int bk = 0; bk < NB; bk++) begin
      for (int j = 0; j < 4; j++) begin
        grp_c[4*bk+j] = carry4(grp_g[4*bk +: 4], grp_p[4*bk +: 4], blk_c[bk], j);
      end
    end

    // Bit carries inside each group.
    for (int k = 0; k < NG; k++) begin
      for (int j = 0; j < 4; j++) begin
        c[4*k+j] = carry4(g[4*k +: 4], p[4*k +: 4], grp_c[k], j);
      end
    end

    s_d  = p ^ c;
    pg_d = &grp_p;
  end

  always_ff @(posedge clk_1Hz) begin
    if (rst) begin
      s_q    <= '0;
      cout_q <= 1'b0;
      pg_q   <= 1'b0;
      gg_q   <= 1'b0;
    end else begin
      s_q    <= s_d;
      cout_q <= cout_d;
      pg_q   <= pg_d;
      gg_q   <= gg_d;
    end
  end

  assign s    = s_q;
  assign cout = cout_q;
  assign pg   = pg_q;
  assign gg   = gg_q;

endmodule

// File: tb/tb_cla.sv
// tb_cla: self-checking bench for cla at WIDTH=4 and WIDTH=8 against an
// arithmetic reference model.
module tb_cla;

  logic       clk;
  logic       rst;
  logic [3:0] a4, b4, s4;
  logic       cin4, cout4, pg4, gg4;
  logic [7:0] a8, b8, s8;
  logic       cin8, cout8, pg8, gg8;

  int n_checks = 0;
  int n_pass   = 0;

  cla #(.WIDTH(4)) u_cla4 (
    .clk_1Hz(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
    .s(s4), .cout(cout4), .pg(pg4), .gg(gg4)
  );

  cla #(.WIDTH(8)) u_cla8 (
    .clk_1Hz(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
    .s(s8), .cout(cout8), .pg(pg8), .gg(gg8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: plain integer addition; pg = every bit differs; gg = carry with cin=0.
  task automatic check4(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                        input logic ec);
    int sum;
    int sum0;
    sum  = int'(ea) + int'(eb) + int'(ec);
    sum0 = int'(ea) + int'(eb);
    check({tag, "_s4"},    16'(s4),    16'(sum % 16));
    check({tag, "_cout4"}, 16'(cout4), 16'(sum / 16));
    check({tag, "_pg4"},   16'(pg4),   16'((ea ^ eb) == 4'hF));
    check({tag, "_gg4"},   16'(gg4),   16'(sum0 / 16));
  endtask

  task automatic check8(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                        input logic ec);
    int sum;
    int sum0;
    sum  = int'(ea) + int'(eb) + int'(ec);
    sum0 = int'(ea) + int'(eb);
    check({tag, "_s8"},    16'(s8),    16'(sum % 256));
    check({tag, "_cout8"}, 16'(cout8), 16'(sum / 256));
    check({tag, "_pg8"},   16'(pg8),   16'((ea ^ eb) == 8'hFF));
    check({tag, "_gg8"},   16'(gg8),   16'(sum0 / 256));
  endtask

  // Drive both DUTs, clock once, then check both a moment after the edge.
  task automatic apply(input string tag, input logic [3:0] va4, input logic [3:0] vb4,
                       input logic vc4, input logic [7:0] va8, input logic [7:0] vb8,
                       input logic vc8);
    a4 = va4; b4 = vb4; cin4 = vc4;
    a8 = va8; b8 = vb8; cin8 = vc8;
    @(posedge clk);
    #1;
    check4(tag, va4, vb4, vc4);
    check8(tag, va8, vb8, vc8);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_s4"},    16'(s4),    16'd0);
    check({tag, "_cout4"}, 16'(cout4), 16'd0);
    check({tag, "_pg4"},   16'(pg4),   16'd0);
    check({tag, "_gg4"},   16'(gg4),   16'd0);
    check({tag, "_s8"},    16'(s8),    16'd0);
    check({tag, "_cout8"}, 16'(cout8), 16'd0);
    check({tag, "_pg8"},   16'(pg8),   16'd0);
    check({tag, "_gg8"},   16'(gg8),   16'd0);
  endtask

  initial begin
    // Reset for two edges with non-zero operands that must be discarded.
    rst = 1'b1;
    a4 = 4'hF; b4 = 4'h0; cin4 = 1'b1;
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    // Directed vectors with literal expectations, plus the model.
    apply("basic1", 4'b0010, 4'b0001, 1'b0, 8'hFF, 8'h00, 1'b1);
    check("basic1_lit_s", 16'(s4), 16'b0011);
    check("corner_ff_lit", 16'({cout8, s8}), 16'h100);
    check("corner_ff_pg", 16'(pg8), 16'd1);
    apply("basic2", 4'b0110, 4'b0010, 1'b1, 8'h80, 8'h80, 1'b0);
    check("basic2_lit_s", 16'(s4), 16'b1001);
    check("corner_80_lit", 16'({gg8, cout8, s8}), 16'h300);
    apply("ovf", 4'b1010, 4'b1101, 1'b0, 8'h0F, 8'h01, 1'b0);
    check("ovf_lit", 16'({gg4, cout4, s4}), 16'b110111);
    // Back-to-back with no bubble.
    apply("b2b_1", 4'b0011, 4'b0100, 1'b0, 8'h7F, 8'h01, 1'b0);
    check("b2b_1_lit", 16'({cout4, s4}), 16'b00111);
    apply("b2b_2", 4'b0011, 4'b0100, 1'b0, 8'hF0, 8'h0F, 1'b1);
    check("b2b_2_lit", 16'({cout4, s4}), 16'b00111);
    // Reset override with fresh operands on the same edge.
    rst = 1'b1;
    a4 = 4'hE; b4 = 4'h7; cin4 = 1'b1;
    a8 = 8'hAB; b8 = 8'hCD; cin8 = 1'b1;
    @(posedge clk);
    #1;
    check_zero("rst_override");
    rst = 1'b0;
    apply("fullprop1", 4'b1111, 4'b0000, 1'b1, 8'h55, 8'hAA, 1'b1);
    check("fullprop1_lit", 16'({gg4, pg4, cout4, s4}), 16'b0110000);
    apply("fullprop0", 4'b1111, 4'b0000, 1'b0, 8'h55, 8'hAA, 1'b0);
    check("fullprop0_lit", 16'({cout4, s4}), 16'b01111);

    // Exhaustive 4-bit sweep; the 8-bit instance runs random vectors alongside.
    for (int i = 0; i < 512; i++) begin
      apply("sweep", 4'(i), 4'(i >> 4), 1'(i >> 8),
            8'($urandom), 8'($urandom), 1'($urandom));
    end
    // Extra 8-bit random vectors, biased towards long carry chains every third one.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra;
      ra = 8'($urandom);
      apply("rand", 4'($urandom), 4'($urandom), 1'($urandom),
            ra, (i % 3 == 0) ? ~ra : 8'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
